// File: rtl/bit_ser_add_ctrl_if.sv
// Requester-side bus of the bit-serial adder sequencer.
// The requester drives operands and start; the sequencer returns busy, done and the sum.
interface bit_ser_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;

  modport master (
    output start, op_a, op_b,
    input  busy, done, sum
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, sum
  );
endinterface

// File: rtl/bit_ser_add_ctrl.sv
// Sequencer for the bit-serial adder: clear, shift LSB-first, capture, return sum with a done pulse.
// Define BSA_CHECK_EN to add a sticky mismatch flag fed by an internal reference adder.
module bit_ser_add_ctrl #(
  parameter int WIDTH   = 8,
  parameter int RES_LAT = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  bit_ser_add_ctrl_if.slave req,
  output logic             ser_a,
  output logic             ser_b,
  output logic             add_clr_n,
  output logic             add_set_n,
  input  logic [WIDTH:0]   add_result
`ifdef BSA_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int CW = $clog2(WIDTH + RES_LAT + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RES_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, FLUSH, WAIT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_a_reg, sh_a_next;
  logic [WIDTH-1:0] sh_b_reg, sh_b_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH:0]   sum_reg, sum_next;
  logic             ser_a_reg, ser_a_next;
  logic             ser_b_reg, ser_b_next;
  logic             add_clr_n_reg, add_clr_n_next;
  logic             add_set_n_reg, add_set_n_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             accept;
  logic             capture;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg     <= IDLE;
      sh_a_reg      <= '0;
      sh_b_reg      <= '0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      ser_a_reg     <= 1'b0;
      ser_b_reg     <= 1'b0;
      add_clr_n_reg <= 1'b0;
      add_set_n_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sh_a_reg      <= sh_a_next;
      sh_b_reg      <= sh_b_next;
      cnt_reg       <= cnt_next;
      sum_reg       <= sum_next;
      ser_a_reg     <= ser_a_next;
      ser_b_reg     <= ser_b_next;
      add_clr_n_reg <= add_clr_n_next;
      add_set_n_reg <= add_set_n_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sh_a_next      = sh_a_reg;
    sh_b_next      = sh_b_reg;
    cnt_next       = cnt_reg;
    sum_next       = sum_reg;
    accept         = 1'b0;
    capture        = 1'b0;
    ser_a_next     = 1'b0;
    ser_b_next     = 1'b0;
    add_clr_n_next = 1'b1;
    add_set_n_next = 1'b1;
    busy_next      = 1'b0;
    done_next      = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (req.start) begin
          accept     = 1'b1;
          state_next = CLEAR;
          sh_a_next  = req.op_a;
          sh_b_next  = req.op_b;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        state_next = SHIFT;
        cnt_next   = '0;
      end
      SHIFT: begin
        if (cnt_reg == SHIFT_LAST) begin
          state_next = FLUSH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FLUSH: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          capture    = 1'b1;
          state_next = DONE;
          sum_next   = add_result;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so every output is a plain register.
    case (state_next)
      CLEAR: begin
        add_clr_n_next = 1'b0;
        busy_next      = 1'b1;
      end
      SHIFT: begin
        ser_a_next = sh_a_reg[0];
        ser_b_next = sh_b_reg[0];
        sh_a_next  = sh_a_reg >> 1;
        sh_b_next  = sh_b_reg >> 1;
        busy_next  = 1'b1;
      end
      FLUSH, WAIT: begin
        add_set_n_next = 1'b0;
        busy_next      = 1'b1;
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

`ifdef BSA_CHECK_EN
  logic [WIDTH:0] ref_reg;
  logic           mismatch_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ref_reg      <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      if (accept) begin
        ref_reg <= {1'b0, req.op_a} + {1'b0, req.op_b};
      end
      if (capture && (add_result != ref_reg)) begin
        mismatch_reg <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_reg;
`endif

  assign ser_a     = ser_a_reg;
  assign ser_b     = ser_b_reg;
  assign add_clr_n = add_clr_n_reg;
  assign add_set_n = add_set_n_reg;
  assign req.busy  = busy_reg;
  assign req.done  = done_reg;
  assign req.sum   = sum_reg;

endmodule

// File: tb/tb_bit_ser_add_ctrl.sv
// Directed bench for bit_ser_add_ctrl with a behavioural bit-serial adder on the datapath side.
// Covers the BSA_CHECK_EN mismatch flag when that macro is defined.
module tb_bit_ser_add_ctrl;
  localparam int WIDTH   = 8;
  localparam int RES_LAT = 1;
  localparam int LAT     = WIDTH + RES_LAT + 2;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  bit_ser_add_ctrl_if #(.WIDTH(WIDTH)) req_if ();

  logic           ser_a, ser_b, add_clr_n, add_set_n;
  logic [WIDTH:0] add_result;
`ifdef BSA_CHECK_EN
  logic           mismatch;
`endif

  bit_ser_add_ctrl #(.WIDTH(WIDTH), .RES_LAT(RES_LAT)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req        (req_if),
    .ser_a      (ser_a),
    .ser_b      (ser_b),
    .add_clr_n  (add_clr_n),
    .add_set_n  (add_set_n),
    .add_result (add_result)
`ifdef BSA_CHECK_EN
    ,
    .mismatch   (mismatch)
`endif
  );

  // Behavioural serial adder: clears on add_clr_n, adds one bit per edge, captures on add_set_n.
  logic [WIDTH-1:0] m_acc;
  logic             m_c;
  logic [3:0]       m_idx;
  logic [WIDTH:0]   m_res;
  logic             force_zero;

  always @(posedge clk) begin
    if (!add_clr_n) begin
      m_acc <= '0;
      m_c   <= 1'b0;
      m_idx <= '0;
    end else if (!add_set_n) begin
      m_res <= force_zero ? '0 : {m_c, m_acc};
    end else if (m_idx < 4'(WIDTH)) begin
      m_acc[m_idx[2:0]] <= ser_a ^ ser_b ^ m_c;
      m_c               <= (ser_a & ser_b) | (m_c & (ser_a ^ ser_b));
      m_idx             <= m_idx + 4'd1;
    end
  end
  assign add_result = m_res;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One operation (optionally with a stray start pulse or start held high), observed for 31 cycles.
  task automatic run_seq(
    input  logic [7:0] a, b,
    input  int         pulse_k, hold_k,
    input  logic [7:0] pa, pb,
    output int         lat1, lat2, dcnt, bcnt,
    output logic [8:0] s1, s2, s_end,
    output logic [7:0] sa, sb
  );
    req_if.start = 1'b1;
    req_if.op_a  = a;
    req_if.op_b  = b;
    lat1 = -1; lat2 = -1; dcnt = 0; bcnt = 0;
    s1 = '0; s2 = '0; sa = '0; sb = '0;
    @(posedge clk); #1;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k >= 1 && k <= WIDTH) begin
        sa[k-1] = ser_a;
        sb[k-1] = ser_b;
      end
      if (req_if.busy) bcnt++;
      if (req_if.done) begin
        dcnt++;
        if (lat1 < 0) begin
          lat1 = k; s1 = req_if.sum;
        end else if (lat2 < 0) begin
          lat2 = k; s2 = req_if.sum;
        end
      end
      req_if.start = (k == pulse_k) || (k < hold_k);
      req_if.op_a  = req_if.start ? pa : 8'($urandom_range(0, 255));
      req_if.op_b  = req_if.start ? pb : 8'($urandom_range(0, 255));
    end
    s_end = req_if.sum;
    $display("op a=%02h b=%02h sum=%0d done_edge=%0d dones=%0d busy_cycles=%0d", a, b, s1, lat1, dcnt, bcnt);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [6];

  int         lat1, lat2, dcnt, bcnt;
  logic [8:0] s1, s2, se;
  logic [7:0] sa, sb;

  initial begin
    vecs[0] = '{8'h07, 8'h03, 9'd10};
    vecs[1] = '{8'hFF, 8'hFF, 9'd510};
    vecs[2] = '{8'h00, 8'h00, 9'd0};
    vecs[3] = '{8'h80, 8'h80, 9'd256};
    vecs[4] = '{8'h3C, 8'h0F, 9'd75};
    vecs[5] = '{8'hA5, 8'h5A, 9'd255};

    clr_n        = 1'b0;
    force_zero   = 1'b0;
    req_if.start = 1'b0;
    req_if.op_a  = '0;
    req_if.op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(req_if.busy), 32'd0);
    chk("rst_done", 32'(req_if.done), 32'd0);
    chk("rst_sum", 32'(req_if.sum), 32'd0);
    chk("rst_ser_a", 32'(ser_a), 32'd0);
    chk("rst_ser_b", 32'(ser_b), 32'd0);
    chk("rst_add_clr_n", 32'(add_clr_n), 32'd0);
    chk("rst_add_set_n", 32'(add_set_n), 32'd1);
`ifdef BSA_CHECK_EN
    chk("rst_mismatch", 32'(mismatch), 32'd0);
`endif
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_add_clr_n", 32'(add_clr_n), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].a, vecs[i].b, -1, 0, 8'h00, 8'h00, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
      chk($sformatf("vec%0d_sum", i), 32'(s1), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat1), 32'(LAT));
      chk($sformatf("vec%0d_done_count", i), 32'(dcnt), 32'd1);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(LAT));
      chk($sformatf("vec%0d_ser_a_bits", i), 32'(sa), 32'(vecs[i].a));
      chk($sformatf("vec%0d_ser_b_bits", i), 32'(sb), 32'(vecs[i].b));
      chk($sformatf("vec%0d_sum_held", i), 32'(se), 32'(vecs[i].exp));
    end
`ifdef BSA_CHECK_EN
    chk("mismatch_clean", 32'(mismatch), 32'd0);
`endif

    // Stray start with new operands during the third SHIFT cycle is dropped.
    run_seq(8'h0F, 8'h01, 3, 0, 8'h55, 8'h55, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
    chk("ignore_sum", 32'(s1), 32'd16);
    chk("ignore_latency", 32'(lat1), 32'(LAT));
    chk("ignore_done_count", 32'(dcnt), 32'd1);
    chk("ignore_sum_held", 32'(se), 32'd16);

    // Start held high through DONE: the second operation starts from DONE, one cycle after the first done.
    run_seq(8'h07, 8'h03, -1, LAT + 1, 8'h01, 8'h01, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
    chk("b2b_sum1", 32'(s1), 32'd10);
    chk("b2b_latency1", 32'(lat1), 32'(LAT));
    chk("b2b_sum2", 32'(s2), 32'd2);
    chk("b2b_latency2", 32'(lat2), 32'(2 * LAT + 1));
    chk("b2b_done_count", 32'(dcnt), 32'd2);
    chk("b2b_busy_cycles", 32'(bcnt), 32'(2 * LAT));

    // Asynchronous reset during the fifth SHIFT cycle.
    req_if.start = 1'b1;
    req_if.op_a  = 8'h33;
    req_if.op_b  = 8'h44;
    @(posedge clk); #1;
    req_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_pre_busy", 32'(req_if.busy), 32'd1);
    chk("midrst_pre_ser_a", 32'(ser_a), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(req_if.busy), 32'd0);
    chk("midrst_done", 32'(req_if.done), 32'd0);
    chk("midrst_sum", 32'(req_if.sum), 32'd0);
    chk("midrst_ser_a", 32'(ser_a), 32'd0);
    chk("midrst_add_clr_n", 32'(add_clr_n), 32'd0);
    chk("midrst_add_set_n", 32'(add_set_n), 32'd1);
    @(posedge clk); #1;
    clr_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (req_if.done) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    run_seq(8'h10, 8'h20, -1, 0, 8'h00, 8'h00, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
    chk("after_rst_sum", 32'(s1), 32'd48);
    chk("after_rst_latency", 32'(lat1), 32'(LAT));

`ifdef BSA_CHECK_EN
    force_zero = 1'b1;
    run_seq(8'h07, 8'h03, -1, 0, 8'h00, 8'h00, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
    force_zero = 1'b0;
    chk("forced_sum_verbatim", 32'(s1), 32'd0);
    chk("mismatch_set", 32'(mismatch), 32'd1);
    run_seq(8'h01, 8'h01, -1, 0, 8'h00, 8'h00, lat1, lat2, dcnt, bcnt, s1, s2, se, sa, sb);
    chk("sticky_sum", 32'(s1), 32'd2);
    chk("mismatch_sticky", 32'(mismatch), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("mismatch_cleared", 32'(mismatch), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule
